uart_rx_fifo: RTL

Downstream stage of the UART receiver (`uart_reciever`). It takes each byte the receiver flags with rdy/data_out and acknowledges it through rdy_clr, then buffers bytes in a DEPTH-entry FIFO. Bytes leave on a first-word-fall-through valid/ready stream for the host/bus side. It reports fill level, sticky overflow and, optionally, a character-timeout flag.

---
 rtl/uart_rx_fifo.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: downstream stage of the UART receiver.
// Acknowledges each byte flagged by the receiver (rx_rdy / rx_rdy_clr),
// buffers it in a DEPTH-entry FIFO and presents it on a first-word-fall-through
// valid/ready stream. Reports fill level and a sticky overflow flag.
// Optional character timeout: define UART_RX_FIFO_TIMEOUT_EN.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   clken          16x baud strobe (timeout counter only)
//   rx_rdy/rx_data receiver byte-ready level and data
//   rx_rdy_clr     one-cycle acknowledge back to the receiver
//   m_valid/m_data head entry (m_data combinational from the read pointer)
//   m_ready        consumer accepts head
//   count          entries held, 0..DEPTH
//   overflow       sticky drop flag, cleared by ovf_clr (a drop wins)
//   rx_timeout     character timeout (0 when the feature is not built)
module uart_rx_fifo #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ADDR_W        = 4,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              rx_rdy_clr,
  output logic              m_valid,
  output logic [7:0]        m_data,
  input  logic              m_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              rx_timeout
);

  localparam int unsigned   CNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } cap_state_e;

  cap_state_e        state_q, state_d;
  logic              rx_rdy_clr_q, rx_rdy_clr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              m_valid_q, m_valid_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        mem_q [DEPTH];

  logic cap_c;
  logic pop_c;
  logic wr_c;
  logic drop_c;

  // Capture only from IDLE: in ACK the receiver still holds rdy for one cycle.
  assign cap_c  = (state_q == IDLE) && rx_rdy;
  assign pop_c  = m_valid_q && m_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign wr_c   = cap_c && ((count_q != FULL_CNT) || pop_c);
  assign drop_c = cap_c && !wr_c;

  // Next-state logic for capture FSM, pointers, level and flags.
  always_comb begin
    state_d      = state_q;
    rx_rdy_clr_d = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          state_d      = ACK;
          rx_rdy_clr_d = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_c)  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_c) rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    case ({wr_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    m_valid_d = (count_d != '0);

    if (ovf_clr) overflow_d = 1'b0;
    if (drop_c)  overflow_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rx_rdy_clr_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      m_valid_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_rdy_clr_q <= rx_rdy_clr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      m_valid_q    <= m_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage array, no reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_c) mem_q[wr_ptr_q] <= rx_data;
  end

  assign rx_rdy_clr = rx_rdy_clr_q;
  assign m_valid    = m_valid_q;
  assign m_data     = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign overflow   = overflow_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam logic [9:0] TO_LIMIT = 10'(TIMEOUT_TICKS);

  logic [9:0] to_cnt_q, to_cnt_d;
  logic       rx_timeout_q, rx_timeout_d;

  // Idle-with-data counter; saturates at the limit and holds the flag.
  always_comb begin
    to_cnt_d     = to_cnt_q;
    rx_timeout_d = rx_timeout_q;
    if (cap_c || pop_c || (count_q == '0)) begin
      to_cnt_d     = '0;
      rx_timeout_d = 1'b0;
    end else if (clken && (to_cnt_q != TO_LIMIT)) begin
      to_cnt_d = to_cnt_q + 10'd1;
      if (to_cnt_d == TO_LIMIT) rx_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q     <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      to_cnt_q     <= to_cnt_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

  assign rx_timeout = rx_timeout_q;
`else
  logic timeout_unused;
  assign timeout_unused = clken ^ (TIMEOUT_TICKS == 0);
  assign rx_timeout     = 1'b0;
`endif

endmodule
